osch: RTL and testbench

Behavioural, synthesizable stand-in for the on-chip oscillator that clocks the TD4 processor's clock divider. It derives a free-running square wave of nominal frequency `NOM_FREQ_KHZ` from a faster reference clock using a fractional phase accumulator. It supports a standby request that stops the output, plus a standby status flag. It sits at the top level and feeds the ripple counter that produces the CPU clock.

---
 rtl/osch_if.sv | 20 ++
 rtl/osch.sv | 116 +++++++++++
 tb/tb_osch.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/osch_if.sv
// osch_if: oscillator-side bundle for osch.
// The master side (the oscillator) drives OSC and SEDSTDBY and receives STDBY.
// The slave side (the clock consumer) drives STDBY and receives OSC and SEDSTDBY.
interface osch_if;
  logic STDBY;
  logic OSC;
  logic SEDSTDBY;

  modport master (
    input  STDBY,
    output OSC,
    output SEDSTDBY
  );

  modport slave (
    output STDBY,
    input  OSC,
    input  SEDSTDBY
  );
endinterface

// File: rtl/osch.sv
// osch: behavioural on-chip oscillator stand-in.
// Derives a square wave of NOM_FREQ_KHZ from a REF_FREQ_KHZ reference clock
// with a fractional phase accumulator. Every run cycle 2*NOM is added to the
// accumulator. Whenever the sum reaches REF, REF is subtracted and OSC toggles.
// Optional standby support is enabled by defining OSCH_STDBY_EN. In that build
// STDBY passes through a two-flop synchronizer, OSC is held low while stopped,
// and SEDSTDBY reports the stopped state. Without the macro, STDBY is ignored
// and SEDSTDBY is tied low.
module osch #(
  parameter int REF_FREQ_KHZ = 50000,
  parameter int NOM_FREQ_KHZ = 2080
) (
  input  logic     clk,
  input  logic     RESET,
  osch_if.master   bus
);

  localparam int AW = $clog2(REF_FREQ_KHZ + 2 * NOM_FREQ_KHZ) + 1;
  localparam logic [AW-1:0] STEP_C = AW'(2 * NOM_FREQ_KHZ);
  localparam logic [AW-1:0] REF_C  = AW'(REF_FREQ_KHZ);

  if ((NOM_FREQ_KHZ < 1) || (NOM_FREQ_KHZ > REF_FREQ_KHZ / 2)) begin : g_bad_param
    $error("osch: NOM_FREQ_KHZ must lie in 1 .. REF_FREQ_KHZ/2");
  end

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_STBY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   sum_s;
  logic            osc_q, osc_d;
  logic            stdby_s;

`ifdef OSCH_STDBY_EN
  logic sync1_q, sync2_q;

  // Two-flop synchronizer bringing the asynchronous STDBY request into clk.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.STDBY;
      sync2_q <= sync1_q;
    end
  end

  assign stdby_s      = sync2_q;
  assign bus.SEDSTDBY = (state_q == ST_STBY);
`else
  logic stdby_unused_s;

  assign stdby_unused_s = bus.STDBY;
  assign stdby_s        = 1'b0;
  assign bus.SEDSTDBY   = 1'b0;
`endif

  // The sum cannot overflow: acc stays below REF and AW holds REF + 2*NOM.
  assign sum_s = acc_q + STEP_C;

  // Next-state logic: phase accumulation while running, forced idle in standby.
  // Leaving standby spends one cycle clearing SEDSTDBY with acc = 0, so the
  // following half-period matches the first one after reset.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    osc_d   = osc_q;
    case (state_q)
      ST_RUN: begin
        if (stdby_s) begin
          state_d = ST_STBY;
          acc_d   = '0;
          osc_d   = 1'b0;
        end else if (sum_s >= REF_C) begin
          acc_d = sum_s - REF_C;
          osc_d = ~osc_q;
        end else begin
          acc_d = sum_s;
        end
      end
      ST_STBY: begin
        acc_d = '0;
        osc_d = 1'b0;
        if (stdby_s) begin
          state_d = ST_STBY;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        acc_d   = '0;
        osc_d   = 1'b0;
      end
    endcase
  end

  // State, accumulator and output register, cleared asynchronously by RESET.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_RUN;
      acc_q   <= '0;
      osc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      osc_q   <= osc_d;
    end
  end

  assign bus.OSC = osc_q;

endmodule

// File: tb/tb_osch.sv
// tb_osch: directed self-checking bench for osch.
// Three instances share clk and RESET: REF=8/NOM=1, REF=10/NOM=2, and the
// default parameters. All outputs are sampled on the falling clock edge.
module tb_osch;

  logic clk;
  logic RESET;

  int   n_vec;
  int   n_err;
  int   edge_n;
  int   cnt10;
  int   cntd;
  logic prev10;
  logic prevd;

  osch_if if8();
  osch_if if10();
  osch_if ifd();

  osch #(.REF_FREQ_KHZ(8),  .NOM_FREQ_KHZ(1)) u_osc8  (.clk(clk), .RESET(RESET), .bus(if8));
  osch #(.REF_FREQ_KHZ(10), .NOM_FREQ_KHZ(2)) u_osc10 (.clk(clk), .RESET(RESET), .bus(if10));
  osch                                        u_oscd  (.clk(clk), .RESET(RESET), .bus(ifd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    edge_n = edge_n + 1;
  endtask

  // Pulse RESET between edges, then release it on a falling edge.
  task automatic restart();
    @(negedge clk);
    #2 RESET = 1'b1;
    @(negedge clk);
    RESET  = 1'b0;
    edge_n = 0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    #1 RESET = 1'b1;
    #1;
    n_vec++; if (if8.OSC !== 1'b0) begin n_err++; $display("FAIL reset_osc8 got=%b exp=0", if8.OSC); end
    n_vec++; if (if10.OSC !== 1'b0) begin n_err++; $display("FAIL reset_osc10 got=%b exp=0", if10.OSC); end
    n_vec++; if (ifd.OSC !== 1'b0) begin n_err++; $display("FAIL reset_oscd got=%b exp=0", ifd.OSC); end
    n_vec++; if (if8.SEDSTDBY !== 1'b0) begin n_err++; $display("FAIL reset_sed8 got=%b exp=0", if8.SEDSTDBY); end
    n_vec++; if (if10.SEDSTDBY !== 1'b0) begin n_err++; $display("FAIL reset_sed10 got=%b exp=0", if10.SEDSTDBY); end
    n_vec++; if (ifd.SEDSTDBY !== 1'b0) begin n_err++; $display("FAIL reset_sedd got=%b exp=0", ifd.SEDSTDBY); end
    @(negedge clk);
    @(negedge clk);
    RESET  = 1'b0;
    edge_n = 0;
    cnt10  = 0;
    cntd   = 0;
    prev10 = 1'b0;
    prevd  = 1'b0;
  endtask

  // Edges 1..16 after release. REF=8/NOM=1 toggles on every 4th edge.
  // REF=10/NOM=2 toggles on edges 3,5,8,10,... so OSC=1 when n%5 >= 3.
  // The defaults give their first rise on edge 13.
  task automatic test_first_edges();
    logic e8, e10, ed;
    for (int i = 0; i < 16; i++) begin
      tick();
      e8  = ((edge_n / 4) % 2) == 1;
      e10 = (edge_n % 5) >= 3;
      ed  = edge_n >= 13;
      n_vec++; if (if8.OSC !== e8) begin n_err++; $display("FAIL osc8_edge%0d got=%b exp=%b", edge_n, if8.OSC, e8); end
      n_vec++; if (if10.OSC !== e10) begin n_err++; $display("FAIL osc10_edge%0d got=%b exp=%b", edge_n, if10.OSC, e10); end
      n_vec++; if (ifd.OSC !== ed) begin n_err++; $display("FAIL oscd_edge%0d got=%b exp=%b", edge_n, ifd.OSC, ed); end
      if (if10.OSC !== prev10) cnt10++;
      if (ifd.OSC !== prevd) cntd++;
      prev10 = if10.OSC;
      prevd  = ifd.OSC;
    end
  endtask

  // Long-run toggle counts from reset: 400 in 1000 edges for 10/2,
  // 20000 in 50000 edges for 10/2, and 4160 in 50000 edges for defaults.
  task automatic test_long_run();
    while (edge_n < 50000) begin
      tick();
      if (if10.OSC !== prev10) cnt10++;
      if (ifd.OSC !== prevd) cntd++;
      prev10 = if10.OSC;
      prevd  = ifd.OSC;
      if (edge_n == 1000) begin
        n_vec++; if (cnt10 !== 400) begin n_err++; $display("FAIL toggles10_1000 got=%0d exp=400", cnt10); end
      end
    end
    n_vec++; if (cnt10 !== 20000) begin n_err++; $display("FAIL toggles10_50000 got=%0d exp=20000", cnt10); end
    n_vec++; if (cntd !== 4160) begin n_err++; $display("FAIL togglesd_50000 got=%0d exp=4160", cntd); end
  endtask

  // RESET asserted between edges while OSC is high clears it at once.
  task automatic test_async_reset_high();
    restart();
    for (int i = 0; i < 5; i++) tick();
    n_vec++; if (if8.OSC !== 1'b1) begin n_err++; $display("FAIL pre_async_osc8 got=%b exp=1", if8.OSC); end
    #2 RESET = 1'b1;
    #1;
    n_vec++; if (if8.OSC !== 1'b0) begin n_err++; $display("FAIL async_osc8 got=%b exp=0", if8.OSC); end
    n_vec++; if (if10.OSC !== 1'b0) begin n_err++; $display("FAIL async_osc10 got=%b exp=0", if10.OSC); end
    n_vec++; if (if8.SEDSTDBY !== 1'b0) begin n_err++; $display("FAIL async_sed8 got=%b exp=0", if8.SEDSTDBY); end
    @(negedge clk);
    RESET  = 1'b0;
    edge_n = 0;
  endtask

`ifdef OSCH_STDBY_EN
  task automatic test_stdby_entry_exit();
    restart();
    for (int i = 0; i < 4; i++) tick();
    n_vec++; if (if8.OSC !== 1'b1) begin n_err++; $display("FAIL stby_pre_osc got=%b exp=1", if8.OSC); end
    if8.STDBY = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_vec++; if (if8.OSC !== (k < 3)) begin n_err++; $display("FAIL stby_in_osc_e%0d got=%b exp=%b", k, if8.OSC, (k < 3)); end
      n_vec++; if (if8.SEDSTDBY !== (k == 3)) begin n_err++; $display("FAIL stby_in_sed_e%0d got=%b exp=%b", k, if8.SEDSTDBY, (k == 3)); end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if ({if8.OSC, if8.SEDSTDBY} !== 2'b01) begin n_err++; $display("FAIL stby_hold got=%b%b exp=01", if8.OSC, if8.SEDSTDBY); end
    end
    if8.STDBY = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_vec++; if (if8.SEDSTDBY !== (k < 3)) begin n_err++; $display("FAIL stby_out_sed_e%0d got=%b exp=%b", k, if8.SEDSTDBY, (k < 3)); end
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_vec++; if (if8.OSC !== (k == 4)) begin n_err++; $display("FAIL stby_resume_e%0d got=%b exp=%b", k, if8.OSC, (k == 4)); end
    end
  endtask

  task automatic test_reset_in_stdby();
    if8.STDBY = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    n_vec++; if (if8.SEDSTDBY !== 1'b1) begin n_err++; $display("FAIL rst_stby_pre got=%b exp=1", if8.SEDSTDBY); end
    #2 RESET = 1'b1;
    #1;
    n_vec++; if (if8.SEDSTDBY !== 1'b0) begin n_err++; $display("FAIL rst_stby_sed got=%b exp=0", if8.SEDSTDBY); end
    n_vec++; if (if8.OSC !== 1'b0) begin n_err++; $display("FAIL rst_stby_osc got=%b exp=0", if8.OSC); end
    @(negedge clk);
    RESET  = 1'b0;
    edge_n = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_vec++; if (if8.SEDSTDBY !== (k == 3)) begin n_err++; $display("FAIL rst_stby_reentry_e%0d got=%b exp=%b", k, if8.SEDSTDBY, (k == 3)); end
    end
    if8.STDBY = 1'b0;
    for (int k = 0; k < 4; k++) tick();
  endtask
`else
  task automatic test_stdby_ignored();
    logic [15:0] pat;
    logic        e8;
    pat = 16'b1011_0010_1110_0101;
    restart();
    for (int i = 0; i < 16; i++) begin
      if8.STDBY = pat[i];
      tick();
      e8 = ((edge_n / 4) % 2) == 1;
      n_vec++; if (if8.OSC !== e8) begin n_err++; $display("FAIL ign_osc_edge%0d got=%b exp=%b", edge_n, if8.OSC, e8); end
      n_vec++; if (if8.SEDSTDBY !== 1'b0) begin n_err++; $display("FAIL ign_sed_edge%0d got=%b exp=0", edge_n, if8.SEDSTDBY); end
    end
    if8.STDBY = 1'b0;
  endtask
`endif

  initial begin
    n_vec      = 0;
    n_err      = 0;
    edge_n     = 0;
    if8.STDBY  = 1'b0;
    if10.STDBY = 1'b0;
    ifd.STDBY  = 1'b0;
    test_reset();
    test_first_edges();
    test_long_run();
    test_async_reset_high();
`ifdef OSCH_STDBY_EN
    test_stdby_entry_exit();
    test_reset_in_stdby();
`else
    test_stdby_ignored();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
